// File: rtl/ucp_pkg.sv
// Shared encodings for the multi-cycle register-CPU control unit:
// instruction classes, FSM state codes and datapath mux selects.
package ucp_pkg;

    localparam logic [2:0] CLS_ALU_RR = 3'd0;
    localparam logic [2:0] CLS_ALU_UN = 3'd1;
    localparam logic [2:0] CLS_LD_DIR = 3'd2;
    localparam logic [2:0] CLS_ST_DIR = 3'd3;
    localparam logic [2:0] CLS_LD_IND = 3'd4;
    localparam logic [2:0] CLS_ST_IND = 3'd5;
    localparam logic [2:0] CLS_BRANCH = 3'd6;
    localparam logic [2:0] CLS_HALT   = 3'd7;

    // Codes are exported on Estado, so they are fixed rather than tool-chosen.
    typedef enum logic [3:0] {
        ST_F1  = 4'd0,
        ST_F2  = 4'd1,
        ST_DEC = 4'd2,
        ST_EX  = 4'd3,
        ST_A1  = 4'd4,
        ST_A2  = 4'd5,
        ST_AI  = 4'd6,
        ST_MRD = 4'd7,
        ST_MWR = 4'd8,
        ST_HLT = 4'd9
    } state_t;

    localparam logic [1:0] SELPC_INC  = 2'b00;
    localparam logic [1:0] SELPC_MEM  = 2'b10;

    localparam logic [1:0] SELAR_PC   = 2'b00;
    localparam logic [1:0] SELAR_MEM  = 2'b01;
    localparam logic [1:0] SELAR_REGA = 2'b10;

    localparam logic [3:0] FUN_PASS   = 4'b1000;

endpackage

// File: rtl/unidad_control_param_if.sv
// Memory request/ready handshake between the control unit and memory.
// The controller holds MemReq/MemWe steady until memory answers with MemReady.
interface unidad_control_param_if;

    logic MemReq;
    logic MemWe;
    logic MemReady;

    modport master (
        output MemReq,
        output MemWe,
        input  MemReady
    );

    modport slave (
        input  MemReq,
        input  MemWe,
        output MemReady
    );

endinterface

// File: rtl/evaluador_condicion.sv
// Branch condition: selects a status flag by Fun index (out-of-range selects
// constant 1) and optionally inverts it with the Fun MSB. Purely combinational.
module evaluador_condicion #(
    parameter int FUN_W  = 4,
    parameter int NFLAGS = 4
) (
    input  logic [FUN_W-1:0]  Fun,
    input  logic [NFLAGS-1:0] Flags,
    output logic              taken
);

    logic [FUN_W-2:0] idx;
    logic             cond;

    assign idx = Fun[FUN_W-2:0];

    always_comb begin
        cond = 1'b1;
        for (int i = 0; i < NFLAGS; i++) begin
            if (int'(idx) == i) begin
                cond = Flags[i];
            end
        end
    end

    assign taken = cond ^ Fun[FUN_W-1];

endmodule

// File: rtl/unidad_control_param.sv
// Multi-cycle control FSM: fetch, decode, ALU, direct/indirect load/store, branch, halt.
// Outputs are combinational; memory states wait on MemReady with requests held stable.
module unidad_control_param
    import ucp_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int FUN_W   = 4,
    parameter int NFLAGS  = 4
) (
    input  logic                  Reloj,
    input  logic                  Reiniciar,
    input  logic [INSTR_W-1:0]    Instruccion,
    input  logic [NFLAGS-1:0]     Flags,
    unidad_control_param_if.master mem,
    output logic                  LoadIR,
    output logic                  LoadPC,
    output logic                  LoadAR,
    output logic                  LoadS,
    output logic                  WriteEnable,
    output logic [1:0]            SelectPC,
    output logic [1:0]            SelectAR,
    output logic                  WriteSelect,
    output logic [REG_AW-1:0]     WriteAddress,
    output logic [REG_AW-1:0]     ReadAddressA,
    output logic [REG_AW-1:0]     ReadAddressB,
    output logic [FUN_W-1:0]      Fun,
    output logic                  Halted,
    output logic [3:0]            Estado
);

    localparam int B_LSB   = 0;
    localparam int A_LSB   = REG_AW;
    localparam int D_LSB   = 2 * REG_AW;
    localparam int FUN_LSB = 3 * REG_AW;
    localparam int CLS_LSB = FUN_LSB + FUN_W;

    state_t              state_q;
    state_t              state_d;

    logic [2:0]          cls;
    logic [FUN_W-1:0]    fld_fun;
    logic [REG_AW-1:0]   fld_d;
    logic [REG_AW-1:0]   fld_a;
    logic [REG_AW-1:0]   fld_b;
    logic                br_taken;
    logic                mem_rdy;
    logic                mem_req;
    logic                mem_we;

    assign cls     = Instruccion[CLS_LSB +: 3];
    assign fld_fun = Instruccion[FUN_LSB +: FUN_W];
    assign fld_d   = Instruccion[D_LSB +: REG_AW];
    assign fld_a   = Instruccion[A_LSB +: REG_AW];
    assign fld_b   = Instruccion[B_LSB +: REG_AW];

    assign mem_rdy    = mem.MemReady;
    assign mem.MemReq = mem_req;
    assign mem.MemWe  = mem_we;

    evaluador_condicion #(
        .FUN_W  (FUN_W),
        .NFLAGS (NFLAGS)
    ) u_cond (
        .Fun   (fld_fun),
        .Flags (Flags),
        .taken (br_taken)
    );

    always_ff @(posedge Reloj) begin
        if (Reiniciar) begin
            state_q <= ST_F1;
        end else begin
            state_q <= state_d;
        end
    end

    assign Estado = Reiniciar ? 4'd0 : state_q;

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        LoadIR       = 1'b0;
        LoadPC       = 1'b0;
        LoadAR       = 1'b0;
        LoadS        = 1'b0;
        WriteEnable  = 1'b0;
        SelectPC     = SELPC_INC;
        SelectAR     = SELAR_PC;
        WriteSelect  = 1'b0;
        WriteAddress = '0;
        ReadAddressA = '0;
        ReadAddressB = '0;
        Fun          = '0;
        Halted       = 1'b0;

        // Reset blanks every output, whatever state the register still holds.
        if (!Reiniciar) begin
            case (state_q)
                ST_F1: begin
                    LoadAR   = 1'b1;
                    SelectAR = SELAR_PC;
                    state_d  = ST_F2;
                end
                ST_F2: begin
                    mem_req = 1'b1;
                    if (mem_rdy) begin
                        LoadIR   = 1'b1;
                        LoadPC   = 1'b1;
                        SelectPC = SELPC_INC;
                        state_d  = ST_DEC;
                    end
                end
                ST_DEC: begin
                    case (cls)
                        CLS_ALU_RR, CLS_ALU_UN:             state_d = ST_EX;
                        CLS_LD_DIR, CLS_ST_DIR, CLS_BRANCH: state_d = ST_A1;
                        CLS_LD_IND, CLS_ST_IND:             state_d = ST_AI;
                        CLS_HALT:                           state_d = ST_HLT;
                        default:                            state_d = ST_HLT;
                    endcase
                end
                ST_EX: begin
                    ReadAddressA = fld_a;
                    ReadAddressB = (cls == CLS_ALU_UN) ? '0 : fld_b;
                    Fun          = fld_fun;
                    WriteAddress = fld_d;
                    WriteEnable  = 1'b1;
                    LoadS        = 1'b1;
                    state_d      = ST_F1;
                end
                ST_A1: begin
                    LoadAR   = 1'b1;
                    SelectAR = SELAR_PC;
                    state_d  = ST_A2;
                end
                ST_A2: begin
                    mem_req = 1'b1;
                    if (mem_rdy) begin
                        LoadPC   = 1'b1;
                        SelectPC = SELPC_INC;
                        case (cls)
                            CLS_LD_DIR: begin
                                LoadAR   = 1'b1;
                                SelectAR = SELAR_MEM;
                                state_d  = ST_MRD;
                            end
                            CLS_ST_DIR: begin
                                LoadAR   = 1'b1;
                                SelectAR = SELAR_MEM;
                                state_d  = ST_MWR;
                            end
                            default: begin
                                // Taken branch loads the target word instead of PC+1.
                                if (br_taken) begin
                                    SelectPC = SELPC_MEM;
                                end
                                state_d = ST_F1;
                            end
                        endcase
                    end
                end
                ST_AI: begin
                    ReadAddressA = fld_a;
                    Fun          = FUN_W'(FUN_PASS);
                    LoadAR       = 1'b1;
                    SelectAR     = SELAR_REGA;
                    state_d      = (cls == CLS_LD_IND) ? ST_MRD : ST_MWR;
                end
                ST_MRD: begin
                    mem_req = 1'b1;
                    if (mem_rdy) begin
                        WriteSelect  = 1'b1;
                        WriteAddress = fld_d;
                        WriteEnable  = 1'b1;
                        state_d      = ST_F1;
                    end
                end
                ST_MWR: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    ReadAddressA = fld_d;
                    if (mem_rdy) begin
                        state_d = ST_F1;
                    end
                end
                ST_HLT: begin
                    Halted = 1'b1;
                end
                default: begin
                    state_d = ST_F1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_control_param.sv
// Scoreboard bench: per-cycle expected output snapshots and MemReady stimulus are
// queued per instruction, then compared against the control unit cycle by cycle.
module tb_unidad_control_param;
    import ucp_pkg::*;

    localparam int INSTR_W = 16;
    localparam int REG_AW  = 3;
    localparam int FUN_W   = 4;
    localparam int NFLAGS  = 4;

    logic                Reloj = 1'b0;
    logic                Reiniciar;
    logic [INSTR_W-1:0]  Instruccion;
    logic [NFLAGS-1:0]   Flags;
    logic                LoadIR, LoadPC, LoadAR, LoadS, WriteEnable, WriteSelect, Halted;
    logic [1:0]          SelectPC, SelectAR;
    logic [REG_AW-1:0]   WriteAddress, ReadAddressA, ReadAddressB;
    logic [FUN_W-1:0]    Fun;
    logic [3:0]          Estado;

    unidad_control_param_if bus ();

    unidad_control_param #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW),
        .FUN_W   (FUN_W),
        .NFLAGS  (NFLAGS)
    ) dut (
        .Reloj        (Reloj),
        .Reiniciar    (Reiniciar),
        .Instruccion  (Instruccion),
        .Flags        (Flags),
        .mem          (bus),
        .LoadIR       (LoadIR),
        .LoadPC       (LoadPC),
        .LoadAR       (LoadAR),
        .LoadS        (LoadS),
        .WriteEnable  (WriteEnable),
        .SelectPC     (SelectPC),
        .SelectAR     (SelectAR),
        .WriteSelect  (WriteSelect),
        .WriteAddress (WriteAddress),
        .ReadAddressA (ReadAddressA),
        .ReadAddressB (ReadAddressB),
        .Fun          (Fun),
        .Halted       (Halted),
        .Estado       (Estado)
    );

    always #5 Reloj = ~Reloj;

    typedef struct packed {
        logic [3:0] est;
        logic       req;
        logic       mwe;
        logic       ir;
        logic       pc;
        logic       ar;
        logic       s;
        logic       we;
        logic       ws;
        logic [1:0] spc;
        logic [1:0] sar;
        logic [2:0] wa;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [3:0] fun;
        logic       hlt;
    } snap_t;

    snap_t exp_q[$];
    logic  stim_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    busy     = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, want %h", tag, $time, obs, exp);
        end
    endtask

    function automatic snap_t sample();
        snap_t s;
        s.est = Estado;       s.req = bus.MemReq;  s.mwe = bus.MemWe;
        s.ir  = LoadIR;       s.pc  = LoadPC;      s.ar  = LoadAR;
        s.s   = LoadS;        s.we  = WriteEnable; s.ws  = WriteSelect;
        s.spc = SelectPC;     s.sar = SelectAR;    s.wa  = WriteAddress;
        s.ra  = ReadAddressA; s.rb  = ReadAddressB;
        s.fun = Fun;          s.hlt = Halted;
        return s;
    endfunction

    function automatic snap_t mk(input logic [3:0] est);
        snap_t s = '0;
        s.est = est;
        return s;
    endfunction

    function automatic logic br_taken(input logic [3:0] f, input logic [3:0] fl);
        logic [7:0] fx;
        fx = {4'hF, fl};
        return fx[f[2:0]] ^ f[3];
    endfunction

    task automatic push(input snap_t e, input logic rdy);
        exp_q.push_back(e);
        stim_q.push_back(rdy);
    endtask

    task automatic push_mem(input snap_t wait_s, input snap_t done_s, input int w);
        for (int i = 0; i < w; i++) push(wait_s, 1'b0);
        push(done_s, 1'b1);
    endtask

    task automatic push_instr(input logic [15:0] ins, input logic [3:0] fl, input int wf, input int wd);
        logic [2:0] cls, dd, a, b;
        logic [3:0] f;
        snap_t      e, w, d;
        cls = ins[15:13]; f = ins[12:9]; dd = ins[8:6]; a = ins[5:3]; b = ins[2:0];
        e = mk(4'd0); e.ar = 1'b1; push(e, 1'b1);
        w = mk(4'd1); w.req = 1'b1; d = w; d.ir = 1'b1; d.pc = 1'b1;
        push_mem(w, d, wf);
        push(mk(4'd2), 1'b1);
        if (cls <= 3'd1) begin
            e = mk(4'd3); e.ra = a; e.rb = (cls == 3'd1) ? 3'd0 : b; e.fun = f;
            e.wa = dd; e.we = 1'b1; e.s = 1'b1;
            push(e, 1'b1);
        end else if (cls == 3'd2 || cls == 3'd3 || cls == 3'd6) begin
            e = mk(4'd4); e.ar = 1'b1; push(e, 1'b1);
            w = mk(4'd5); w.req = 1'b1; d = w; d.pc = 1'b1;
            if (cls != 3'd6) begin
                d.ar = 1'b1; d.sar = 2'b01;
            end else if (br_taken(f, fl)) begin
                d.spc = 2'b10;
            end
            push_mem(w, d, wd);
        end else if (cls == 3'd4 || cls == 3'd5) begin
            e = mk(4'd6); e.ra = a; e.fun = 4'b1000; e.ar = 1'b1; e.sar = 2'b10;
            push(e, 1'b1);
        end
        if (cls == 3'd2 || cls == 3'd4) begin
            w = mk(4'd7); w.req = 1'b1; d = w; d.ws = 1'b1; d.we = 1'b1; d.wa = dd;
            push_mem(w, d, wd);
        end else if (cls == 3'd3 || cls == 3'd5) begin
            w = mk(4'd8); w.req = 1'b1; w.mwe = 1'b1; w.ra = dd;
            push_mem(w, w, wd);
        end
    endtask

    task automatic step(input string tag);
        bus.MemReady = (stim_q.size() > 0) ? stim_q.pop_front() : 1'b1;
        #1;
        if (Estado != 4'd0) busy++;
        if (exp_q.size() > 0) check_eq(tag, 64'(sample()), 64'(exp_q.pop_front()));
        @(negedge Reloj);
    endtask

    task automatic run_instr(input string tag, input logic [15:0] ins, input logic [3:0] fl,
                             input int wf, input int wd, input int exp_cyc);
        Instruccion = ins;
        Flags       = fl;
        busy        = 0;
        push_instr(ins, fl, wf, wd);
        while (exp_q.size() > 0) step(tag);
        bus.MemReady = 1'b1;
        #1;
        check_eq({tag, "_ret_f1"}, 64'(Estado), 64'(0));
        check_eq({tag, "_cycles"}, 64'(busy + 1), 64'(exp_cyc));
    endtask

    function automatic logic [15:0] enc(input logic [2:0] c, input logic [3:0] f,
                                        input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
        return {c, f, d, a, b};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        snap_t f1;
        f1 = mk(4'd0);
        f1.ar = 1'b1;
        Reiniciar    = 1'b1;
        Instruccion  = '0;
        Flags        = '0;
        bus.MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Reloj);
            #1;
            check_eq("reset_outs", 64'(sample()), 64'(0));
        end
        Reiniciar = 1'b0;

        run_instr("alu_rr",   16'h0A53,              4'b0000, 0, 0, 4);
        run_instr("alu_un",   enc(1, 4'h2, 5, 6, 7), 4'b0000, 2, 0, 6);
        run_instr("ld_dir",   enc(2, 4'h0, 3, 0, 0), 4'b0000, 0, 3, 12);
        run_instr("st_dir",   enc(3, 4'h0, 2, 0, 0), 4'b0000, 1, 1, 9);
        run_instr("br_t",     enc(6, 4'b0001, 0, 0, 0), 4'b0010, 0, 0, 5);
        run_instr("br_nt",    enc(6, 4'b1001, 0, 0, 0), 4'b0010, 0, 1, 6);
        run_instr("br_alw",   enc(6, 4'b0111, 0, 0, 0), 4'b0000, 0, 0, 5);
        run_instr("ld_ind",   enc(4, 4'h0, 3, 5, 0), 4'b0000, 0, 2, 7);
        run_instr("st_ind",   enc(5, 4'h0, 6, 4, 0), 4'b0000, 0, 0, 5);

        // Reset lands in MRD while memory is still stalling.
        Instruccion = enc(2, 4'h0, 5, 0, 0);
        push_instr(Instruccion, 4'b0000, 0, 4);
        for (int i = 0; i < 11; i++) step("rst_pre");
        exp_q.delete();
        stim_q.delete();
        Reiniciar    = 1'b1;
        bus.MemReady = 1'b1;
        #1;
        check_eq("rst_mrd_outs", 64'(sample()), 64'(0));
        @(negedge Reloj);
        #1;
        check_eq("rst_hold_outs", 64'(sample()), 64'(0));
        Reiniciar = 1'b0;
        #1;
        check_eq("rst_release_f1", 64'(sample()), 64'(f1));
        run_instr("post_rst", 16'h0A53, 4'b0000, 0, 0, 4);

        Instruccion = enc(7, 4'h0, 0, 0, 0);
        push_instr(Instruccion, 4'b0000, 0, 0);
        for (int i = 0; i < 100; i++) begin
            snap_t h;
            h = mk(4'd9);
            h.hlt = 1'b1;
            push(h, 1'b1);
        end
        while (exp_q.size() > 0) step("halt");
        Reiniciar = 1'b1;
        #1;
        check_eq("halt_rst_outs", 64'(sample()), 64'(0));
        @(negedge Reloj);
        Reiniciar = 1'b0;
        #1;
        check_eq("halt_rst_f1", 64'(sample()), 64'(f1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
